zbt_image_reader: RTL

Fetches a stored image frame from ZBT SRAM and unpacks each 36-bit word into a stream of 8-bit pixels for the display pipeline. It is the read-side counterpart of the ZBT image packing path, which stores four pixels per word with the first pixel in bits [7:0] and bits [35:32] zero. The block issues read requests through the ZBT arbiter, tracks fixed-latency returns in a small word FIFO, and emits pixels under a valid/ready handshake.

---
 rtl/zbt_image_reader.sv | 115 +++++++++++
 1 files changed

// File: rtl/zbt_image_reader.sv
// zbt_image_reader: streams a ZBT-stored frame out as 8-bit pixels, four per 36-bit word.
// Define ZBT_READER_NIBBLE_CHECK_EN to add the sticky nibble_err flag for nonzero bits [35:32].
module zbt_image_reader #(
  parameter int ADDR_WIDTH  = 19,
  parameter int FRAME_WORDS = 76800,
  parameter int RD_LATENCY  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  zbt_rd_req,
  output logic [ADDR_WIDTH-1:0] zbt_addr,
  input  logic                  zbt_grant,
  input  logic [35:0]           zbt_rd_data,
  output logic [7:0]            pixel,
  output logic                  pixel_valid,
  input  logic                  pixel_ready,
  output logic                  busy,
  output logic                  frame_done
`ifdef ZBT_READER_NIBBLE_CHECK_EN
  ,
  output logic                  nibble_err
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_WORDS + 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CW-1:0] issued;
  logic [RD_LATENCY-1:0] trk;
  logic cap_v;
  logic [35:0] cap_d;
  logic [31:0] mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr, count;
  logic [31:0] word;
  logic [1:0] idx;
  logic gnt, pop, hs, last_byte;
  int occ;
  assign count = wr_ptr - rd_ptr;
  // Credit counts every word already owed to the FIFO, including the capture stage.
  always_comb begin
    occ = int'(count) + int'(cap_v);
    for (int i = 0; i < RD_LATENCY; i++) occ += int'(trk[i]);
  end
  assign zbt_rd_req = state == FETCH && occ < FIFO_DEPTH;
  assign gnt        = zbt_rd_req && zbt_grant;
  assign zbt_addr   = addr;
  assign hs         = pixel_valid && pixel_ready;
  assign last_byte  = hs && idx == 2'd3;
  assign pop        = count != 0 && (!pixel_valid || last_byte);
  assign pixel      = word[8*idx +: 8];
  assign busy       = state != IDLE;
  assign frame_done = state == DONE;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = start ? FETCH : IDLE;
      FETCH:   state_nx = (gnt && issued == CW'(FRAME_WORDS - 1)) ? DRAIN : FETCH;
      DRAIN:   state_nx = (trk == '0 && !cap_v && count == 0 && (!pixel_valid || last_byte)) ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      addr        <= '0;
      issued      <= '0;
      trk         <= '0;
      cap_v       <= 1'b0;
      cap_d       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      word        <= '0;
      idx         <= '0;
      pixel_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        addr   <= base_addr;
        issued <= '0;
      end else if (gnt) begin
        addr   <= addr + 1'b1;
        issued <= issued + 1'b1;
      end
      trk   <= RD_LATENCY'({trk, gnt});
      cap_v <= trk[RD_LATENCY-1];
      cap_d <= zbt_rd_data;
      if (cap_v) begin
        mem[wr_ptr[PW-1:0]] <= cap_d[31:0];
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        word        <= mem[rd_ptr[PW-1:0]];
        rd_ptr      <= rd_ptr + 1'b1;
        idx         <= '0;
        pixel_valid <= 1'b1;
      end else if (hs) begin
        idx         <= idx + 1'b1;
        pixel_valid <= idx != 2'd3;
      end
    end
  end
`ifdef ZBT_READER_NIBBLE_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset_n || (state == IDLE && start)) nibble_err <= 1'b0;
    else if (cap_v && cap_d[35:32] != 4'd0) nibble_err <= 1'b1;
  end
`else
  logic unused_nibble;
  assign unused_nibble = ^cap_d[35:32];
`endif
endmodule
